multicycle_control_unit: RTL

- Sequencer for the multi-cycle MIPS datapath. It replaces the single-cycle decoder when instruction fetch and data access share one memory port.
- Decodes opcode/funct from the instruction register and steps a state machine through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select, and stalls on a memory ready handshake.
- Sits between the instruction register, ALU zero flag, unified memory interface and register file.

---
 rtl/multicycle_control_unit_if.sv | 18 +
 rtl/multicycle_control_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
// Unified memory port handshake between the control unit and the memory.
interface multicycle_control_unit_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS sequencer: decodes the instruction register and steps
// fetch/decode/execute/memory/writeback, driving all datapath enables and
// selects. It stalls on the shared memory port's ready handshake.
//
// state  | meaning
// -------+-----------------------------------------------
// FETCH  | read instruction, PC <= PC+4 when memory ready
// DECODE | decode IR, ALUOut <= PC + (imm<<2)
// MEMADR | address = rs + signext(imm)
// MEMRD  | data read, wait for memory ready
// MEMWB  | rt <= memory data
// MEMWR  | data write, wait for memory ready
// RTEX   | ALU op rs,rt selected by funct
// RTWB   | rd <= ALUOut
// BEQ    | compare rs,rt; PC <= branch target when equal
// ADDIEX | rs + signext(imm)
// ADDIWB | rt <= ALUOut
// JUMP   | PC <= jump target
// JAL    | $31 <= PC (already +4), PC <= jump target
// JR     | PC <= rs
// TRAP   | unsupported instruction, parked until reset
module multicycle_control_unit #(
    parameter int STATE_W = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [5:0]                    opcode,
    input  logic [5:0]                    funct,
    input  logic                          zero,
    multicycle_control_unit_if.master     mem,
    output logic                          ir_we,
    output logic                          pc_we,
    output logic                          rf_we,
    output logic [1:0]                    sel_pc,
    output logic [1:0]                    sel_result,
    output logic [1:0]                    sel_wa,
    output logic                          sel_alu_a,
    output logic [1:0]                    sel_alu_b,
    output logic [3:0]                    alu_ctrl,
    output logic                          instr_done,
    output logic                          illegal,
    output logic [STATE_W-1:0]            state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        RTWB   = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        JAL    = 4'd12,
        JR     = 4'd13,
        TRAP   = 4'd14
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t state_q;
    state_t state_d;
    logic   mem_req_c;
    logic   mem_we_c;

    // State register and sticky illegal flag, set on the edge that enters TRAP.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q != TRAP && state_d == TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

    // Next-state decode and per-state datapath controls; reset masks all writes.
    always_comb begin
        state_d    = state_q;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        sel_pc     = 2'b00;
        sel_result = 2'b00;
        sel_wa     = 2'b00;
        sel_alu_a  = 1'b0;
        sel_alu_b  = 2'b00;
        alu_ctrl   = ALU_AND;
        instr_done = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req_c = 1'b1;
                sel_alu_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                ir_we     = mem.mem_ready;
                pc_we     = mem.mem_ready;
                if (mem.mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                sel_alu_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    6'h23, 6'h2B: state_d = MEMADR;
                    6'h08:        state_d = ADDIEX;
                    6'h04:        state_d = BEQ;
                    6'h02:        state_d = JUMP;
                    6'h03:        state_d = JAL;
                    6'h00: begin
                        case (funct)
                            6'h08:                            state_d = JR;
                            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: state_d = RTEX;
                            default:                          state_d = TRAP;
                        endcase
                    end
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR: begin
                sel_alu_a = 1'b1;
                sel_alu_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = (opcode == 6'h2B) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req_c = 1'b1;
                if (mem.mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                rf_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_req_c  = 1'b1;
                mem_we_c   = 1'b1;
                instr_done = mem.mem_ready;
                if (mem.mem_ready) begin
                    state_d = FETCH;
                end
            end
            RTEX: begin
                sel_alu_a = 1'b1;
                case (funct)
                    6'h22:   alu_ctrl = ALU_SUB;
                    6'h24:   alu_ctrl = ALU_AND;
                    6'h25:   alu_ctrl = ALU_OR;
                    6'h2A:   alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
                state_d = RTWB;
            end
            RTWB: begin
                rf_we      = 1'b1;
                sel_result = 2'b01;
                sel_wa     = 2'b01;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BEQ: begin
                sel_alu_a  = 1'b1;
                alu_ctrl   = ALU_SUB;
                sel_pc     = 2'b01;
                pc_we      = zero;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ADDIEX: begin
                sel_alu_a = 1'b1;
                sel_alu_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                rf_we      = 1'b1;
                sel_result = 2'b01;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                sel_pc     = 2'b10;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JAL: begin
                rf_we      = 1'b1;
                sel_result = 2'b10;
                sel_wa     = 2'b10;
                sel_pc     = 2'b10;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JR: begin
                sel_pc     = 2'b11;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
            end
        endcase

        if (reset) begin
            mem_req_c  = 1'b0;
            mem_we_c   = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            rf_we      = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign mem.mem_req = mem_req_c;
    assign mem.mem_we  = mem_we_c;
    assign state       = STATE_W'(state_q);

endmodule
